// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared state encodings for the skid-buffered selector
package mux_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Only a full skid buffer refuses new beats.
    function automatic logic ready_in(state_t s);
        return s != ST_TWO;
    endfunction

endpackage

// File: rtl/mux_n_comb.sv
// rtl/mux_n_comb.sv - combinational NUM_IN:1 selector with out-of-range flag
module mux_n_comb #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        data,
    output logic                    err
);

    // Out-of-range selects fall through to zero data.
    always_comb begin
        data = '0;
        err  = int'(sel) >= NUM_IN;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(sel) == k) begin
                data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_n_skid.sv
// rtl/mux_n_skid.sv - N-way selector with registered valid/ready output and 2-entry skid
module mux_n_skid
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err_sticky
);

    state_t           state, state_n;
    logic             ready_q;
    logic [WIDTH-1:0] main_data, skid_data, sel_data;
    logic             main_err, skid_err, sel_err;
    logic             accept, consume;
    logic             load_main, main_from_skid, load_skid;

    mux_n_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_sel (
        .in_data (in_data),
        .sel     (in_sel),
        .data    (sel_data),
        .err     (sel_err)
    );

    assign in_ready   = ready_q;
    assign out_valid  = state != ST_EMPTY;
    assign out_data   = main_data;
    assign out_err    = main_err;
    assign accept     = in_valid && ready_q;
    assign consume    = out_valid && out_ready;

    always_comb begin
        state_n        = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_n   = ST_ONE;
                    load_main = 1'b1;
                end
            end
            ST_ONE: begin
                case ({accept, consume})
                    2'b10: begin
                        state_n   = ST_TWO;
                        load_skid = 1'b1;
                    end
                    2'b11:   load_main = 1'b1;
                    2'b01:   state_n   = ST_EMPTY;
                    default: state_n   = ST_ONE;
                endcase
            end
            ST_TWO: begin
                if (consume) begin
                    state_n        = ST_ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_n = ST_EMPTY;
        endcase
    end

    // in_ready is flopped from the next state so it never sees out_ready combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_EMPTY;
            ready_q    <= 1'b1;
            main_data  <= '0;
            main_err   <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state   <= state_n;
            ready_q <= ready_in(state_n);
            if (load_main) begin
                main_data <= sel_data;
                main_err  <= sel_err;
            end else if (main_from_skid) begin
                main_data <= skid_data;
                main_err  <= skid_err;
            end
            if (load_skid) begin
                skid_data <= sel_data;
                skid_err  <= sel_err;
            end
            if (accept && sel_err) begin
                err_sticky <= 1'b1;
            end
        end
    end

endmodule
